// File: rtl/xb_rd_stream_arbiter_pkg.sv
// xb_stream_pkg: shared FSM state, header layout and round-robin helpers for the read-stream arbiter
package xb_stream_pkg;
   typedef enum logic [1:0] {IDLE, HDR, BODY, DRAIN} state_e;
   localparam logic [7:0] HDR_MAGIC_DFLT = 8'hA5;
   localparam int HDR_TAG_W = 8;
   localparam int HDR_CH_W = 8;
   localparam int HDR_SEQ_OFS = HDR_TAG_W + HDR_CH_W;
   function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
      logic [3:0] r;
      r = ptr;
      for (int k = 15; k >= 0; k--)
         if (k < n && req[(int'(ptr) + k) % n]) r = 4'((int'(ptr) + k) % n);
      return r;
   endfunction
   function automatic logic [3:0] rr_next(input logic [3:0] ptr, input int n);
      return 4'((int'(ptr) + 1) % n);
   endfunction
endpackage

// File: rtl/xb_rd_stream_arbiter_if.sv
// xb_rd_stream_arbiter_if: source-FIFO side and host read-stream side of the arbiter
interface xb_rd_stream_arbiter_if #(parameter int N_CH = 4, parameter int DATA_W = 32);
   localparam int CW = $clog2(N_CH);
   logic [N_CH*DATA_W-1:0] ch_data_w;
   logic [N_CH-1:0]        ch_last_w;
   logic [N_CH-1:0]        ch_empty_w;
   logic [N_CH-1:0]        ch_eof_w;
   logic [N_CH-1:0]        ch_rden_w;
   logic                   user_r_open_w;
   logic                   user_r_rden_w;
   logic [DATA_W-1:0]      user_r_data_w;
   logic                   user_r_empty_w;
   logic                   user_r_eof_w;
   logic [CW-1:0]          cur_ch_w;
   modport master (
      output ch_data_w, ch_last_w, ch_empty_w, ch_eof_w, user_r_open_w, user_r_rden_w,
      input  ch_rden_w, user_r_data_w, user_r_empty_w, user_r_eof_w, cur_ch_w
   );
   modport slave (
      input  ch_data_w, ch_last_w, ch_empty_w, ch_eof_w, user_r_open_w, user_r_rden_w,
      output ch_rden_w, user_r_data_w, user_r_empty_w, user_r_eof_w, cur_ch_w
   );
endinterface

// File: rtl/xb_rd_stream_arbiter_obuf2.sv
// xb_obuf2: 2-entry synchronous FIFO with registered (non-FWFT) read data and flush
module xb_obuf2 #(parameter int DATA_W = 32) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [1:0]        count,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop_ok, push_ok;
   assign full    = cnt_q == 2'd2;
   assign empty   = cnt_q == 2'd0;
   assign count   = cnt_q;
   assign rd_data = rd_data_q;
   // a pop frees a slot in the same cycle, so a full buffer still accepts a push alongside a pop
   always_comb begin
      pop_ok    = pop & !empty & !flush;
      push_ok   = push & (!full | pop_ok) & !flush;
      mem_d     = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = push_data;
      rd_data_d = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;
      wr_ptr_d  = flush ? 1'b0 : wr_ptr_q ^ push_ok;
      rd_ptr_d  = flush ? 1'b0 : rd_ptr_q ^ pop_ok;
      cnt_d     = flush ? 2'd0 : cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
   end
   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q     <= '{default: '0};
         rd_data_q <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         mem_q     <= mem_d;
         rd_data_q <= rd_data_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: rtl/xb_rd_stream_arbiter.sv
// xb_rd_stream_arbiter: packet-atomic round-robin mux of N FWFT sources onto one Xillybus read stream
module xb_rd_stream_arbiter
   import xb_stream_pkg::*;
#(
   parameter int         N_CH      = 4,
   parameter int         DATA_W    = 32,
   parameter int         SEQ_W     = 16,
   parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DFLT
) (
   input  logic                   bus_clk_w,
   input  logic                   trn_reset_n_w,
   xb_rd_stream_arbiter_if.slave  bus
);
   localparam int CW = $clog2(N_CH);
   state_e                      state_q, state_d;
   logic [CW-1:0]               cur_ch_q, cur_ch_d, rr_q, rr_d;
   logic [N_CH-1:0][SEQ_W-1:0]  seq_q, seq_d;
   logic                        eof_q, eof_d;
   logic [N_CH-1:0]             ch_rden;
   logic                        push, open, src_valid, src_last, host_pop, space;
   logic                        ob_full, ob_empty;
   logic [1:0]                  ob_cnt;
   logic [DATA_W-1:0]           push_data, hdr, src_data;
   assign open      = bus.user_r_open_w;
   assign src_data  = bus.ch_data_w[int'(cur_ch_q)*DATA_W +: DATA_W];
   assign src_valid = !bus.ch_empty_w[cur_ch_q];
   assign src_last  = bus.ch_last_w[cur_ch_q];
   assign host_pop  = open & bus.user_r_rden_w & !ob_empty;
   assign space     = !ob_full | host_pop;
   assign bus.ch_rden_w      = ch_rden;
   assign bus.user_r_empty_w = ob_empty | !open;
   assign bus.user_r_eof_w   = eof_q;
   assign bus.cur_ch_w       = cur_ch_q;
   // header word: tag, channel id, sequence number, zero padding below
   always_comb begin
      hdr = '0;
      hdr[DATA_W-1 -: HDR_TAG_W]            = HDR_MAGIC;
      hdr[DATA_W-HDR_TAG_W-1 -: HDR_CH_W]   = 8'(cur_ch_q);
      hdr[DATA_W-HDR_SEQ_OFS-1 -: SEQ_W]    = seq_q[cur_ch_q];
   end
   // packet FSM: once a channel is chosen no other channel is popped until its last word
   always_comb begin
      state_d   = state_q;
      cur_ch_d  = cur_ch_q;
      rr_d      = rr_q;
      seq_d     = seq_q;
      ch_rden   = '0;
      push      = 1'b0;
      push_data = src_data;
      case (state_q)
         IDLE:
            if (open && |(~bus.ch_empty_w)) begin
               cur_ch_d = CW'(rr_pick(16'(~bus.ch_empty_w), 4'(rr_q), N_CH));
               state_d  = HDR;
            end
         HDR:
            if (!open) state_d = IDLE;
            else if (space) begin
               push             = 1'b1;
               push_data        = hdr;
               seq_d[cur_ch_q]  = seq_q[cur_ch_q] + 1'b1;
               state_d          = BODY;
            end
         BODY:
            if (!open) state_d = DRAIN;
            else if (src_valid && space) begin
               ch_rden[cur_ch_q] = 1'b1;
               push              = 1'b1;
               if (src_last) begin
                  rr_d    = CW'(rr_next(4'(cur_ch_q), N_CH));
                  state_d = IDLE;
               end
            end
         DRAIN:
            if (src_valid) begin
               ch_rden[cur_ch_q] = 1'b1;
               if (src_last) begin
                  rr_d    = CW'(rr_next(4'(cur_ch_q), N_CH));
                  state_d = IDLE;
               end
            end
         default: state_d = IDLE;
      endcase
      eof_d = open & (&bus.ch_eof_w) & (&bus.ch_empty_w) & (ob_cnt == 2'd0) & (state_q == IDLE);
   end
   // state registers
   always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
      if (!trn_reset_n_w) begin
         state_q  <= IDLE;
         cur_ch_q <= '0;
         rr_q     <= '0;
         seq_q    <= '0;
         eof_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_ch_q <= cur_ch_d;
         rr_q     <= rr_d;
         seq_q    <= seq_d;
         eof_q    <= eof_d;
      end
   end
   xb_obuf2 #(.DATA_W(DATA_W)) u_obuf (
      .clk       (bus_clk_w),
      .rst_n     (trn_reset_n_w),
      .flush     (!open),
      .push      (push),
      .push_data (push_data),
      .pop       (host_pop),
      .full      (ob_full),
      .empty     (ob_empty),
      .count     (ob_cnt),
      .rd_data   (bus.user_r_data_w)
   );
endmodule

// File: tb/tb_xb_rd_stream_arbiter.sv
// tb_xb_rd_stream_arbiter: directed tests of the read-stream arbiter with FWFT source models and a host reader
module tb_xb_rd_stream_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_n = 0;
   int   tot_n = 0;
   int   cyc = 0;
   always #5 clk = ~clk;

   xb_rd_stream_arbiter_if #(.N_CH(4), .DATA_W(32)) bus ();
   xb_rd_stream_arbiter_if #(.N_CH(4), .DATA_W(32)) bus2 ();

   xb_rd_stream_arbiter #(.N_CH(4), .DATA_W(32), .SEQ_W(16), .HDR_MAGIC(8'hA5)) dut (
      .bus_clk_w(clk), .trn_reset_n_w(rst_n), .bus(bus));
   xb_rd_stream_arbiter #(.N_CH(4), .DATA_W(32), .SEQ_W(2), .HDR_MAGIC(8'hA5)) dut2 (
      .bus_clk_w(clk), .trn_reset_n_w(rst_n), .bus(bus2));

   // FWFT source models: {last, data} per entry, head advanced by ch_rden
   logic [32:0] smem [4][64];
   logic [5:0]  hd [4] = '{default: 6'd0};
   logic [5:0]  tl [4] = '{default: 6'd0};
   logic [32:0] smem2 [32];
   logic [4:0]  hd2 = 5'd0;
   logic [4:0]  tl2 = 5'd0;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bus.ch_data_w[i*32 +: 32] = smem[i][hd[i]][31:0];
         bus.ch_last_w[i]          = smem[i][hd[i]][32];
         bus.ch_empty_w[i]         = hd[i] == tl[i];
      end
      bus2.ch_data_w  = {96'd0, smem2[hd2][31:0]};
      bus2.ch_last_w  = {3'b000, smem2[hd2][32]};
      bus2.ch_empty_w = {3'b111, hd2 == tl2};
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) if (bus.ch_rden_w[i]) hd[i] <= hd[i] + 6'd1;
      if (bus2.ch_rden_w[0]) hd2 <= hd2 + 5'd1;
   end

   // host readers: data is valid one cycle after an accepted read strobe
   logic [31:0] rx [64];
   int          rx_t [64];
   int          rx_n = 0;
   logic        acc1;
   always @(posedge clk) begin
      acc1 = bus.user_r_rden_w && !bus.user_r_empty_w;
      #1;
      if (acc1) begin
         rx[rx_n]   = bus.user_r_data_w;
         rx_t[rx_n] = cyc;
         rx_n++;
      end
   end

   logic [31:0] rx2 [32];
   int          rx2_n = 0;
   logic        acc2;
   always @(posedge clk) begin
      acc2 = bus2.user_r_rden_w && !bus2.user_r_empty_w;
      #1;
      if (acc2) begin
         rx2[rx2_n] = bus2.user_r_data_w;
         rx2_n++;
      end
   end

   task automatic push_word(input int ch, input logic [31:0] d, input logic last);
      smem[ch][tl[ch]] = {last, d};
      tl[ch] = tl[ch] + 6'd1;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tot_n++; if (bus.user_r_empty_w !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.user_r_empty_w); else pass_n++;
      tot_n++; if (bus.user_r_eof_w !== 1'b0) $display("FAIL reset_eof got %b want 0", bus.user_r_eof_w); else pass_n++;
      tot_n++; if (bus.user_r_data_w !== 32'h0) $display("FAIL reset_data got %h want 00000000", bus.user_r_data_w); else pass_n++;
      tot_n++; if (bus.cur_ch_w !== 2'd0) $display("FAIL reset_cur_ch got %0d want 0", bus.cur_ch_w); else pass_n++;
      tot_n++; if (bus.ch_rden_w !== 4'b0) $display("FAIL reset_rden got %b want 0000", bus.ch_rden_w); else pass_n++;
      rst_n = 1'b1;
      bus.user_r_open_w = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.ch_rden_w !== 4'b0 || bus.user_r_empty_w !== 1'b1 || bus.user_r_eof_w !== 1'b0) bad++;
      end
      tot_n++; if (bad != 0) $display("FAIL idle_open_empty bad_cycles got %0d want 0", bad); else pass_n++;
   endtask

   task automatic test_single_packet();
      logic [31:0] exp [4];
      int b;
      exp = '{32'hA5020000, 32'h11, 32'h22, 32'h33};
      b = rx_n;
      push_word(2, 32'h11, 1'b0);
      push_word(2, 32'h22, 1'b0);
      push_word(2, 32'h33, 1'b1);
      bus.user_r_rden_w = 1'b1;
      for (int n = 0; n < 30 && rx_n < b + 4; n++) @(negedge clk);
      bus.user_r_rden_w = 1'b0;
      tot_n++; if (rx_n - b != 4) $display("FAIL single_count got %0d want 4", rx_n - b); else pass_n++;
      for (int k = 0; k < 4; k++) begin
         tot_n++; if (rx[b+k] !== exp[k]) $display("FAIL single_word%0d got %h want %h", k, rx[b+k], exp[k]); else pass_n++;
      end
      tot_n++; if (rx_t[b+3] - rx_t[b] != 3) $display("FAIL single_rate span got %0d want 3", rx_t[b+3] - rx_t[b]); else pass_n++;
      repeat (2) @(negedge clk);
      tot_n++; if (bus.user_r_empty_w !== 1'b1) $display("FAIL single_empty_after got %b want 1", bus.user_r_empty_w); else pass_n++;
      tot_n++; if (hd[2] !== 6'd3) $display("FAIL single_popped got %0d want 3", hd[2]); else pass_n++;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp [10];
      int b;
      exp = '{32'hA5000000, 32'h100, 32'h101, 32'hA5030000, 32'h300, 32'h301,
              32'hA5000001, 32'h102, 32'hA5030001, 32'h302};
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      b = rx_n;
      push_word(0, 32'h100, 1'b0);
      push_word(0, 32'h101, 1'b1);
      push_word(0, 32'h102, 1'b1);
      push_word(3, 32'h300, 1'b0);
      push_word(3, 32'h301, 1'b1);
      push_word(3, 32'h302, 1'b1);
      bus.user_r_rden_w = 1'b1;
      for (int n = 0; n < 80 && rx_n < b + 10; n++) @(negedge clk);
      bus.user_r_rden_w = 1'b0;
      tot_n++; if (rx_n - b != 10) $display("FAIL rr_count got %0d want 10", rx_n - b); else pass_n++;
      for (int k = 0; k < 10; k++) begin
         tot_n++; if (rx[b+k] !== exp[k]) $display("FAIL rr_word%0d got %h want %h", k, rx[b+k], exp[k]); else pass_n++;
      end
   endtask

   task automatic test_close_drain();
      int b;
      logic [5:0] h0;
      b = rx_n;
      h0 = hd[1];
      for (int k = 0; k < 5; k++) push_word(1, 32'h10 + k, k == 4);
      push_word(1, 32'h20, 1'b0);
      push_word(1, 32'h21, 1'b1);
      bus.user_r_rden_w = 1'b1;
      for (int n = 0; n < 30 && rx_n < b + 2; n++) @(negedge clk);
      bus.user_r_rden_w = 1'b0;
      bus.user_r_open_w = 1'b0;
      repeat (20) @(negedge clk);
      tot_n++; if (rx_n - b != 2) $display("FAIL close_host_words got %0d want 2", rx_n - b); else pass_n++;
      tot_n++; if (rx[b] !== 32'hA5010000) $display("FAIL close_hdr got %h want a5010000", rx[b]); else pass_n++;
      tot_n++; if (rx[b+1] !== 32'h10) $display("FAIL close_body0 got %h want 00000010", rx[b+1]); else pass_n++;
      tot_n++; if (6'(hd[1] - h0) !== 6'd5) $display("FAIL close_drained got %0d want 5", 6'(hd[1] - h0)); else pass_n++;
      tot_n++; if (bus.user_r_empty_w !== 1'b1) $display("FAIL close_empty got %b want 1", bus.user_r_empty_w); else pass_n++;
      bus.user_r_open_w = 1'b1;
      bus.user_r_rden_w = 1'b1;
      for (int n = 0; n < 30 && rx_n < b + 5; n++) @(negedge clk);
      bus.user_r_rden_w = 1'b0;
      tot_n++; if (rx[b+2] !== 32'hA5010001) $display("FAIL reopen_hdr got %h want a5010001", rx[b+2]); else pass_n++;
      tot_n++; if (rx[b+3] !== 32'h20) $display("FAIL reopen_w0 got %h want 00000020", rx[b+3]); else pass_n++;
      tot_n++; if (rx[b+4] !== 32'h21) $display("FAIL reopen_w1 got %h want 00000021", rx[b+4]); else pass_n++;
      tot_n++; if (6'(hd[1] - h0) !== 6'd7) $display("FAIL reopen_popped got %0d want 7", 6'(hd[1] - h0)); else pass_n++;
   endtask

   task automatic test_backpressure();
      int b;
      logic [5:0] h0;
      b = rx_n;
      h0 = hd[0];
      for (int k = 0; k < 6; k++) push_word(0, 32'h40 + k, k == 5);
      bus.user_r_rden_w = 1'b0;
      repeat (20) @(negedge clk);
      tot_n++; if (6'(hd[0] - h0) !== 6'd1) $display("FAIL bp_popped_stalled got %0d want 1", 6'(hd[0] - h0)); else pass_n++;
      tot_n++; if (bus.user_r_empty_w !== 1'b0) $display("FAIL bp_not_empty got %b want 0", bus.user_r_empty_w); else pass_n++;
      bus.user_r_rden_w = 1'b1;
      for (int n = 0; n < 40 && rx_n < b + 7; n++) @(negedge clk);
      bus.user_r_rden_w = 1'b0;
      tot_n++; if (rx[b] !== 32'hA5000002) $display("FAIL bp_hdr got %h want a5000002", rx[b]); else pass_n++;
      for (int k = 0; k < 6; k++) begin
         tot_n++; if (rx[b+1+k] !== 32'h40 + k) $display("FAIL bp_word%0d got %h want %h", k, rx[b+1+k], 32'h40 + k); else pass_n++;
      end
      tot_n++; if (rx_t[b+6] - rx_t[b] != 6) $display("FAIL bp_contiguous span got %0d want 6", rx_t[b+6] - rx_t[b]); else pass_n++;
   endtask

   task automatic test_eof();
      bus.ch_eof_w = 4'b1111;
      repeat (3) @(negedge clk);
      tot_n++; if (bus.user_r_eof_w !== 1'b1) $display("FAIL eof_all got %b want 1", bus.user_r_eof_w); else pass_n++;
      tot_n++; if (bus.user_r_empty_w !== 1'b1) $display("FAIL eof_empty got %b want 1", bus.user_r_empty_w); else pass_n++;
      bus.ch_eof_w = 4'b1011;
      repeat (2) @(negedge clk);
      tot_n++; if (bus.user_r_eof_w !== 1'b0) $display("FAIL eof_partial got %b want 0", bus.user_r_eof_w); else pass_n++;
      bus.ch_eof_w = 4'b1111;
      repeat (2) @(negedge clk);
      bus.user_r_open_w = 1'b0;
      repeat (2) @(negedge clk);
      tot_n++; if (bus.user_r_eof_w !== 1'b0) $display("FAIL eof_closed got %b want 0", bus.user_r_eof_w); else pass_n++;
      bus.user_r_open_w = 1'b1;
      bus.ch_eof_w = 4'b0000;
   endtask

   task automatic test_seq_wrap();
      logic [31:0] exp [10];
      int b;
      exp = '{32'hA5000000, 32'h50, 32'hA5004000, 32'h51, 32'hA5008000, 32'h52,
              32'hA500C000, 32'h53, 32'hA5000000, 32'h54};
      b = rx2_n;
      for (int k = 0; k < 5; k++) begin
         smem2[tl2] = {1'b1, 32'h50 + k};
         tl2 = tl2 + 5'd1;
      end
      bus2.user_r_open_w = 1'b1;
      bus2.user_r_rden_w = 1'b1;
      for (int n = 0; n < 80 && rx2_n < b + 10; n++) @(negedge clk);
      bus2.user_r_rden_w = 1'b0;
      tot_n++; if (rx2_n - b != 10) $display("FAIL wrap_count got %0d want 10", rx2_n - b); else pass_n++;
      for (int k = 0; k < 10; k++) begin
         tot_n++; if (rx2[b+k] !== exp[k]) $display("FAIL wrap_word%0d got %h want %h", k, rx2[b+k], exp[k]); else pass_n++;
      end
   endtask

   initial begin
      bus.user_r_open_w  = 1'b0;
      bus.user_r_rden_w  = 1'b0;
      bus.ch_eof_w       = 4'b0000;
      bus2.user_r_open_w = 1'b0;
      bus2.user_r_rden_w = 1'b0;
      bus2.ch_eof_w      = 4'b0000;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_close_drain();
      test_backpressure();
      test_eof();
      test_seq_wrap();
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
